i2c_cfg_seq: RTL and testbench



---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_cfg_seq_if.sv | 23 ++
 rtl/i2c_cfg_rom.sv | 30 +++
 rtl/i2c_cfg_seq.sv | 156 +++++++++++++++
 tb/tb_i2c_cfg_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-init sequencer: FSM states and the
// layout of one {reg_addr, data} table entry.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_REQ,
      ST_WAIT,
      ST_GAP,
      ST_RETRY,
      ST_GAP_R,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam int ENTRY_W  = 24;
   localparam int ADDR_MSB = 23;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   function automatic logic [15:0] entry_addr(input logic [ENTRY_W-1:0] e);
      return e[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
      return e[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/i2c_cfg_seq_if.sv
// Bus between the init sequencer (master) and the I2C byte driver (slave).
interface i2c_cfg_seq_if;

   logic [15:0] iic_addr;
   logic        wr_req;
   logic [7:0]  wr_data;
   logic [5:0]  wr_byte_num;
   logic        rd_req;
   logic        req_new_byte;
   logic        curr_work_done;
   logic        iic_error;

   modport master (
      output iic_addr, wr_req, wr_data, wr_byte_num, rd_req,
      input  req_new_byte, curr_work_done, iic_error
   );

   modport slave (
      input  iic_addr, wr_req, wr_data, wr_byte_num, rd_req,
      output req_new_byte, curr_work_done, iic_error
   );

endinterface

// File: rtl/i2c_cfg_rom.sv
// Synchronous init-table ROM, one clock read latency. The table is a packed
// parameter with entry 0 in the least significant 24 bits.
module i2c_cfg_rom
   import i2c_pkg::*;
#(
   parameter int ROM_AW = 4,
   parameter logic [(2**ROM_AW)*ENTRY_W-1:0] INIT_TABLE = '0
) (
   input  logic               clk,
   input  logic [ROM_AW-1:0]  i_addr,
   output logic [ENTRY_W-1:0] o_data
);

   localparam int DEPTH = 2**ROM_AW;

   logic [ENTRY_W-1:0] w_table [DEPTH];
   logic [ENTRY_W-1:0] r_data;

   for (genvar g = 0; g < DEPTH; g++) begin : g_table
      assign w_table[g] = INIT_TABLE[g*ENTRY_W +: ENTRY_W];
   end

   // NOTE: the read register has no reset; like a RAM output it only needs to be valid one clock after an address is presented.
   always_ff @(posedge clk) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/i2c_cfg_seq.sv
// Register-init sequencer: walks the ROM table, issues one single-byte write
// per entry, waits a post-write gap, retries NACKs and reports done/fail.
module i2c_cfg_seq
   import i2c_pkg::*;
#(
   parameter int CMD_NUM    = 16,
   parameter int ROM_AW     = 4,
   parameter int GAP_CYCLES = 250_000,
   parameter int MAX_RETRY  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_fail,
   output logic [ROM_AW-1:0]  o_fail_idx,
   output logic [ROM_AW-1:0]  o_rom_addr,
   input  logic [ENTRY_W-1:0] i_rom_data,
   i2c_cfg_seq_if.master      iic
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(CMD_NUM - 1);

   state_t              r_state;
   logic [ROM_AW-1:0]   r_index;
   logic [RW-1:0]       r_retry;
   logic [GW-1:0]       r_gap;
   logic [ROM_AW-1:0]   r_fail_idx;
   logic [15:0]         r_iic_addr;
   logic [7:0]          r_wr_data;
   logic                r_wr_req;
   logic                r_done;
   logic                r_fail;
   logic                r_done_d1, r_done_d2;
   logic                r_err_d1, r_err_d2;
   logic                w_done_rise;
   logic                w_err_rise;

   // Driver status levels last many clocks; only their rising edges count.
   assign w_done_rise = r_done_d1 & ~r_done_d2;
   assign w_err_rise  = r_err_d1  & ~r_err_d2;

   // NOTE: every register below uses non-blocking assignment so all updates in a clock see the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_index    <= '0;
         r_retry    <= '0;
         r_gap      <= '0;
         r_fail_idx <= '0;
         r_iic_addr <= '0;
         r_wr_data  <= '0;
         r_wr_req   <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_done_d1  <= 1'b0;
         r_done_d2  <= 1'b0;
         r_err_d1   <= 1'b0;
         r_err_d2   <= 1'b0;
      end else begin
         r_done_d1 <= iic.curr_work_done;
         r_done_d2 <= r_done_d1;
         r_err_d1  <= iic.iic_error;
         r_err_d2  <= r_err_d1;

         r_wr_req <= 1'b0;
         r_done   <= 1'b0;
         r_fail   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_index    <= '0;
                  r_retry    <= '0;
                  r_fail_idx <= '0;
                  r_state    <= ST_FETCH;
               end
            end
            ST_FETCH: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_iic_addr <= entry_addr(i_rom_data);
               r_wr_data  <= entry_data(i_rom_data);
               r_wr_req   <= 1'b1;
               r_state    <= ST_REQ;
            end
            ST_REQ: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (w_err_rise) begin
                  r_state <= ST_RETRY;
               end else if (w_done_rise) begin
                  r_gap   <= '0;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_gap == GAP_LAST) begin
                  if (r_index == LAST_IDX) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_index <= r_index + ROM_AW'(1);
                     r_retry <= '0;
                     r_state <= ST_FETCH;
                  end
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            ST_RETRY: begin
               // Hold off until the driver has released its error level.
               if (!r_err_d1) begin
                  if (r_retry == RETRY_MAX) begin
                     r_fail     <= 1'b1;
                     r_fail_idx <= r_index;
                     r_state    <= ST_FAIL;
                  end else begin
                     r_retry <= r_retry + RW'(1);
                     r_gap   <= '0;
                     r_state <= ST_GAP_R;
                  end
               end
            end
            ST_GAP_R: begin
               if (r_gap == GAP_LAST) begin
                  r_wr_req <= 1'b1;
                  r_state  <= ST_REQ;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            ST_FAIL: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = r_done;
   assign o_fail     = r_fail;
   assign o_fail_idx = r_fail_idx;
   assign o_rom_addr = r_index;

   assign iic.iic_addr    = r_iic_addr;
   assign iic.wr_req      = r_wr_req;
   assign iic.wr_data     = r_wr_data;
   assign iic.wr_byte_num = 6'd0;
   assign iic.rd_req      = 1'b0;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Self-checking bench for i2c_cfg_seq: behavioural I2C driver, ROM beside the
// sequencer, scoreboard of expected write transactions.
module tb_i2c_cfg_seq;
   import i2c_pkg::*;

   localparam int CMD_NUM    = 6;
   localparam int ROM_AW     = 3;
   localparam int GAP_CYCLES = 10;
   localparam int MAX_RETRY  = 2;

   localparam logic [23:0] EXP_TAB [6] = '{
      24'h300882, 24'h310303, 24'h3017FF, 24'h3018FC, 24'h30341A, 24'h303521
   };
   localparam logic [8*24-1:0] ROM_INIT = {
      24'h000000, 24'h000000, 24'h303521, 24'h30341A,
      24'h3018FC, 24'h3017FF, 24'h310303, 24'h300882
   };

   typedef enum logic [1:0] {R_ACK, R_NACK, R_BOTH} resp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic              o_busy, o_done, o_fail;
   logic [ROM_AW-1:0] o_fail_idx, o_rom_addr;
   logic [23:0]       w_rom_data;

   i2c_cfg_seq_if iic ();

   i2c_cfg_seq #(
      .CMD_NUM(CMD_NUM), .ROM_AW(ROM_AW),
      .GAP_CYCLES(GAP_CYCLES), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
      .o_done(o_done), .o_fail(o_fail), .o_fail_idx(o_fail_idx),
      .o_rom_addr(o_rom_addr), .i_rom_data(w_rom_data), .iic(iic)
   );

   i2c_cfg_rom #(.ROM_AW(ROM_AW), .INIT_TABLE(ROM_INIT)) u_rom (
      .clk(clk), .i_addr(o_rom_addr), .o_data(w_rom_data)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cycle = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          fail_cnt = 0;
   int          last_wr = -1;
   logic [23:0] sb_q [$];

   logic [15:0] nack_addr = 16'h0;
   int          nack_left = 0;
   logic [15:0] both_addr = 16'h0;
   int          both_left = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard pops on each write request, counts pulses.
   always @(negedge clk) begin
      logic [23:0] e;
      cycle++;
      if (o_done === 1'b1) done_cnt++;
      if (o_fail === 1'b1) fail_cnt++;
      if (iic.wr_req === 1'b1) begin
         wr_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected wr_req", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("wr addr", 32'(iic.iic_addr), 32'(e[23:8]));
            check("wr data", 32'(iic.wr_data), 32'(e[7:0]));
         end
         if (last_wr >= 0) check("gap >= GAP_CYCLES", 32'(cycle - last_wr >= GAP_CYCLES), 32'd1);
         last_wr = cycle;
      end
   end

   // Driver model: responds to each request after a few clocks with a
   // multi-clock done and/or error level; pokes req_new_byte meanwhile.
   always begin
      logic [15:0] req_addr;
      logic [7:0]  req_data;
      resp_t       resp;
      @(negedge clk);
      if (rst_n && iic.wr_req === 1'b1) begin
         req_addr = iic.iic_addr;
         req_data = iic.wr_data;
         resp = R_ACK;
         if (both_left > 0 && req_addr == both_addr) begin
            resp = R_BOTH;
            both_left--;
         end else if (nack_left > 0 && req_addr == nack_addr) begin
            resp = R_NACK;
            nack_left--;
         end
         @(negedge clk); iic.req_new_byte = 1'b1;
         @(negedge clk); iic.req_new_byte = 1'b0;
         @(negedge clk); iic.req_new_byte = 1'b1;
         @(negedge clk); iic.req_new_byte = 1'b0;
         iic.curr_work_done = (resp != R_NACK);
         iic.iic_error      = (resp != R_ACK);
         repeat (3) @(negedge clk);
         check("addr held through driver done", 32'(iic.iic_addr), 32'(req_addr));
         check("data held through driver done", 32'(iic.wr_data), 32'(req_data));
         iic.curr_work_done = 1'b0;
         iic.iic_error      = 1'b0;
      end
   end

   task automatic push_entries(input int first, input int last);
      for (int i = first; i <= last; i++) sb_q.push_back(EXP_TAB[i]);
   endtask

   task automatic start_and_latency();
      int k;
      last_wr = -1;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      k = 1;
      while (iic.wr_req !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("start to first wr_req latency", 32'(k), 32'd3);
   endtask

   task automatic wait_end(input logic exp_done);
      int k;
      k = 0;
      while (o_done !== 1'b1 && o_fail !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("run ended within bound", 32'(k < 3000), 32'd1);
      check("o_done at end", 32'(o_done), 32'(exp_done));
      check("o_fail at end", 32'(o_fail), 32'(!exp_done));
      check("busy high during end pulse", 32'(o_busy), 32'd1);
      @(negedge clk);
      check("busy low after end pulse", 32'(o_busy), 32'd0);
      check("end pulse one clk", 32'({o_done, o_fail}), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 32'({o_busy, o_done, o_fail, o_fail_idx, o_rom_addr}), 32'd0);
      check(tag, 32'({iic.iic_addr, iic.wr_data, iic.wr_req}), 32'd0);
      check(tag, 32'({iic.wr_byte_num, iic.rd_req}), 32'd0);
   endtask

   initial begin
      int base, dbase, fbase, k;
      iic.req_new_byte   = 1'b0;
      iic.curr_work_done = 1'b0;
      iic.iic_error      = 1'b0;

      #3 check_all_zero("reset outputs");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Run 1: every write ACKed
      base = wr_cnt; dbase = done_cnt;
      push_entries(0, 5);
      start_and_latency();
      check("first wr addr 3008", 32'(iic.iic_addr), 32'h3008);
      check("first wr data 82", 32'(iic.wr_data), 32'h82);
      wait_end(1'b1);
      check("run1 wr count", 32'(wr_cnt - base), 32'd6);
      check("run1 done pulses", 32'(done_cnt - dbase), 32'd1);

      // Run 2: entry 1 NACKed twice, then ACKed
      nack_addr = 16'h3103; nack_left = 2;
      base = wr_cnt;
      push_entries(0, 1); push_entries(1, 1); push_entries(1, 5);
      start_and_latency();
      wait_end(1'b1);
      check("run2 wr count", 32'(wr_cnt - base), 32'd8);

      // Run 3: entry 3 always NACKed -> fail after 3 attempts
      nack_addr = 16'h3018; nack_left = 99;
      base = wr_cnt; dbase = done_cnt; fbase = fail_cnt;
      push_entries(0, 3); push_entries(3, 3); push_entries(3, 3);
      start_and_latency();
      wait_end(1'b0);
      check("fail_idx", 32'(o_fail_idx), 32'd3);
      repeat (20) @(negedge clk);
      check("fail_idx held", 32'(o_fail_idx), 32'd3);
      check("run3 wr count", 32'(wr_cnt - base), 32'd6);
      check("run3 no done", 32'(done_cnt - dbase), 32'd0);
      check("run3 fail pulses", 32'(fail_cnt - fbase), 32'd1);
      nack_left = 0;

      // Run 4: done+error rise together on entry 0; stray start while busy
      both_addr = 16'h3008; both_left = 1;
      base = wr_cnt;
      push_entries(0, 0); push_entries(0, 5);
      start_and_latency();
      check("fail_idx cleared on start", 32'(o_fail_idx), 32'd0);
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      wait_end(1'b1);
      check("run4 wr count", 32'(wr_cnt - base), 32'd7);

      // Run 5: reset during the gap after entry 5, then restart
      base = wr_cnt; dbase = done_cnt;
      push_entries(0, 5);
      start_and_latency();
      k = 0;
      while (wr_cnt - base < 6 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("reached entry 5", 32'(wr_cnt - base), 32'd6);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("async reset outputs");
      check("scoreboard drained at reset", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("no done across reset", 32'(done_cnt - dbase), 32'd0);
      base = wr_cnt;
      push_entries(0, 5);
      start_and_latency();
      check("restart at entry 0", 32'(iic.iic_addr), 32'h3008);
      wait_end(1'b1);
      check("run5 wr count", 32'(wr_cnt - base), 32'd6);
      check("scoreboard empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
